// File: rtl/axil_reg_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axil_reg_pkg;

  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH     = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0]     strb;
  } wbeat_t;

  // Replace only the byte lanes enabled by strb.
  function automatic logic [AXI_DATA_WIDTH-1:0] byte_merge(
    input logic [AXI_DATA_WIDTH-1:0] old_v,
    input logic [AXI_DATA_WIDTH-1:0] new_v,
    input logic [STRB_WIDTH-1:0]     strb
  );
    logic [AXI_DATA_WIDTH-1:0] res;
    res = old_v;
    for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
      if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_if.sv
// AXI4-Lite bus bundle between the VIP master and the register slave.
interface axil_reg_if
  import axil_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) ();

  logic [ADDR_WIDTH-1:0]     s_axi_awaddr;
  logic [2:0]                s_axi_awprot;
  logic                      s_axi_awvalid;
  logic                      s_axi_awready;
  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_WIDTH-1:0]     s_axi_wstrb;
  logic                      s_axi_wvalid;
  logic                      s_axi_wready;
  logic [1:0]                s_axi_bresp;
  logic                      s_axi_bvalid;
  logic                      s_axi_bready;
  logic [ADDR_WIDTH-1:0]     s_axi_araddr;
  logic [2:0]                s_axi_arprot;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [AXI_DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]                s_axi_rresp;
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_rready
  );

endinterface

// File: rtl/axil_reg_wr_ctrl.sv
// Write-channel control: AW/W holding buffers, write FSM and commit decode.
// AXIL_DECODE_ERR_EN selects SLVERR on out-of-range index instead of aliasing.
module axil_reg_wr_ctrl
  import axil_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         awaddr_i,
  input  logic                          awvalid_i,
  output logic                          awready_c_o,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
  input  logic [STRB_WIDTH-1:0]         wstrb_i,
  input  logic                          wvalid_i,
  output logic                          wready_c_o,
  output logic                          bvalid_o,
  output resp_t                         bresp_o,
  input  logic                          bready_i,
  output logic                          commit_c_o,
  output logic [ADDR_WIDTH-3:0]         commit_idx_c_o,
  output wbeat_t                        commit_beat_c_o,
  output logic                          commit_err_c_o
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  wr_state_t        state_q, state_d;
  logic             aw_full_q, aw_full_d;
  logic             w_full_q, w_full_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  wbeat_t           w_beat_q, w_beat_d;
  resp_t            bresp_q, bresp_d;
  logic             aw_hs, w_hs;
  logic [IDX_W-1:0] raw_idx;
  wbeat_t           in_beat;
  logic             unused_ok;

  assign unused_ok = ^awaddr_i[1:0];
  assign in_beat   = '{data: wdata_i, strb: wstrb_i};

  // Channels stall while a buffer is occupied or a response is outstanding.
  assign awready_c_o = !rst_i && !aw_full_q && (state_q == W_IDLE);
  assign wready_c_o  = !rst_i && !w_full_q  && (state_q == W_IDLE);
  assign aw_hs       = awvalid_i && awready_c_o;
  assign w_hs        = wvalid_i  && wready_c_o;

  assign raw_idx         = aw_full_q ? aw_idx_q : awaddr_i[ADDR_WIDTH-1:2];
  assign commit_beat_c_o = w_full_q ? w_beat_q : in_beat;
  assign commit_c_o      = (state_q == W_IDLE) && (aw_full_q || aw_hs) && (w_full_q || w_hs);

`ifdef AXIL_DECODE_ERR_EN
  assign commit_idx_c_o = raw_idx;
  assign commit_err_c_o = (32'(raw_idx) >= NUM_REGS);
`else
  assign commit_idx_c_o = IDX_W'(32'(raw_idx) % NUM_REGS);
  assign commit_err_c_o = 1'b0;
`endif

  assign bvalid_o = (state_q == W_RESP);
  assign bresp_o  = bresp_q;

  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_beat_d  = w_beat_q;
    bresp_d   = bresp_q;
    case (state_q)
      W_IDLE: begin
        if (commit_c_o) begin
          state_d   = W_RESP;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          bresp_d   = commit_err_c_o ? RESP_SLVERR : RESP_OKAY;
        end else begin
          if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = awaddr_i[ADDR_WIDTH-1:2];
          end
          if (w_hs) begin
            w_full_d = 1'b1;
            w_beat_d = in_beat;
          end
        end
      end
      W_RESP: begin
        if (bready_i) begin
          state_d = W_IDLE;
          bresp_d = RESP_OKAY;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= W_IDLE;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_beat_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_beat_q  <= w_beat_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: register array, read FSM, parallel register export.
// AXIL_DECODE_ERR_EN selects SLVERR on out-of-range index instead of aliasing.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axil_reg_if.slave                      s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  wr_commit_c;
  logic [IDX_W-1:0]      wr_idx_c;
  wbeat_t                wr_beat_c;
  logic                  wr_err_c;
  resp_t                 bresp;

  rd_state_t             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_lookup_c;
  resp_t                 rresp_q, rresp_d;
  logic [IDX_W-1:0]      ar_raw_idx, ar_idx_c;
  logic                  ar_err_c, ar_hs;
  logic                  unused_ok;

  assign unused_ok = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot, s_axi.s_axi_araddr[1:0]};

  axil_reg_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_ctrl (
    .clk_i           (ACLK),
    .rst_i           (ARESET),
    .awaddr_i        (s_axi.s_axi_awaddr),
    .awvalid_i       (s_axi.s_axi_awvalid),
    .awready_c_o     (s_axi.s_axi_awready),
    .wdata_i         (s_axi.s_axi_wdata),
    .wstrb_i         (s_axi.s_axi_wstrb),
    .wvalid_i        (s_axi.s_axi_wvalid),
    .wready_c_o      (s_axi.s_axi_wready),
    .bvalid_o        (s_axi.s_axi_bvalid),
    .bresp_o         (bresp),
    .bready_i        (s_axi.s_axi_bready),
    .commit_c_o      (wr_commit_c),
    .commit_idx_c_o  (wr_idx_c),
    .commit_beat_c_o (wr_beat_c),
    .commit_err_c_o  (wr_err_c)
  );

  assign s_axi.s_axi_bresp = bresp;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_commit_c && !wr_err_c) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx_c == IDX_W'(i)) regs_q[i] <= byte_merge(regs_q[i], wr_beat_c.data, wr_beat_c.strb);
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign ar_raw_idx = s_axi.s_axi_araddr[ADDR_WIDTH-1:2];
`ifdef AXIL_DECODE_ERR_EN
  assign ar_idx_c = ar_raw_idx;
  assign ar_err_c = (32'(ar_raw_idx) >= NUM_REGS);
`else
  assign ar_idx_c = IDX_W'(32'(ar_raw_idx) % NUM_REGS);
  assign ar_err_c = 1'b0;
`endif

  // Lookup sees pre-edge register contents, so a same-edge write is not visible.
  always_comb begin
    rd_lookup_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_c == IDX_W'(i)) rd_lookup_c = regs_q[i];
    end
  end

  assign s_axi.s_axi_arready = !ARESET && (rd_state_q == R_IDLE);
  assign ar_hs               = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
  assign s_axi.s_axi_rvalid  = (rd_state_q == R_DATA);
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_DATA;
          rdata_d    = ar_err_c ? '0 : rd_lookup_c;
          rresp_d    = ar_err_c ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA: begin
        if (s_axi.s_axi_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave (ADDR_WIDTH=5, NUM_REGS=4); honours AXIL_DECODE_ERR_EN.
module tb_axil_reg_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] reg_out;
  int           n_tests = 0;
  int           n_fail  = 0;

`ifdef AXIL_DECODE_ERR_EN
  localparam logic [31:0] REG0_END = 32'h12BB00DD;
`else
  localparam logic [31:0] REG0_END = 32'hDEADBEEF;
`endif

  axil_reg_if #(.ADDR_WIDTH(5)) bus ();

  axil_reg_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_REGS   (4)
  ) dut (
    .ACLK    (clk),
    .ARESET  (rst),
    .s_axi   (bus.slave),
    .reg_out (reg_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic [1:0] ep);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_rdata = er; v.exp_resp = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic ok);
    logic aw_done, w_done, aw_hs, w_hs;
    int   n;
    aw_done = 1'b0; w_done = 1'b0; n = 0; ok = 1'b1;
    bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata = d; bus.s_axi_wstrb = s; bus.s_axi_wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
      w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
      step();
      if (aw_hs) begin bus.s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    if (!(aw_done && w_done)) ok = 1'b0;
    bus.s_axi_bready = 1'b1;
    n = 0;
    while (!bus.s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.s_axi_bvalid) ok = 1'b0;
    resp = bus.s_axi_bresp;
    step();
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output logic ok);
    logic ar_done, ar_hs;
    int   n;
    ar_done = 1'b0; n = 0; ok = 1'b1;
    bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
    while (!ar_done && n < 20) begin
      ar_hs = bus.s_axi_arvalid && bus.s_axi_arready;
      step();
      if (ar_hs) begin bus.s_axi_arvalid = 1'b0; ar_done = 1'b1; end
      n++;
    end
    bus.s_axi_arvalid = 1'b0;
    if (!ar_done) ok = 1'b0;
    bus.s_axi_rready = 1'b1;
    n = 0;
    while (!bus.s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.s_axi_rvalid) ok = 1'b0;
    data = bus.s_axi_rdata;
    resp = bus.s_axi_rresp;
    step();
    bus.s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        ok;

    rst = 1'b1;
    bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;

    add_vec(1'b1, 5'h00, 32'h1, 4'hF, 32'h0, 2'b00);
    add_vec(1'b1, 5'h04, 32'h2, 4'hF, 32'h0, 2'b00);
    add_vec(1'b1, 5'h08, 32'h3, 4'hF, 32'h0, 2'b00);
    add_vec(1'b1, 5'h0C, 32'h4, 4'hF, 32'h0, 2'b00);
    add_vec(1'b0, 5'h00, 32'h0, 4'h0, 32'h1, 2'b00);
    add_vec(1'b0, 5'h04, 32'h0, 4'h0, 32'h2, 2'b00);
    add_vec(1'b0, 5'h08, 32'h0, 4'h0, 32'h3, 2'b00);
    add_vec(1'b0, 5'h0C, 32'h0, 4'h0, 32'h4, 2'b00);
    add_vec(1'b1, 5'h00, 32'hAABBCCDD, 4'b0101, 32'h0, 2'b00);
    add_vec(1'b0, 5'h00, 32'h0, 4'h0, 32'h00BB00DD, 2'b00);
    add_vec(1'b1, 5'h01, 32'h12345678, 4'b1000, 32'h0, 2'b00);
    add_vec(1'b0, 5'h03, 32'h0, 4'h0, 32'h12BB00DD, 2'b00);
`ifdef AXIL_DECODE_ERR_EN
    add_vec(1'b1, 5'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b10);
    add_vec(1'b0, 5'h10, 32'h0, 4'h0, 32'h0, 2'b10);
    add_vec(1'b0, 5'h00, 32'h0, 4'h0, 32'h12BB00DD, 2'b00);
    add_vec(1'b0, 5'h1C, 32'h0, 4'h0, 32'h0, 2'b10);
`else
    add_vec(1'b1, 5'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    add_vec(1'b0, 5'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
    add_vec(1'b0, 5'h00, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00);
    add_vec(1'b0, 5'h1C, 32'h0, 4'h0, 32'h4, 2'b00);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst awready", 128'(bus.s_axi_awready), 128'(1));
    chk("rst wready",  128'(bus.s_axi_wready),  128'(1));
    chk("rst arready", 128'(bus.s_axi_arready), 128'(1));
    chk("rst bvalid",  128'(bus.s_axi_bvalid),  128'(0));
    chk("rst rvalid",  128'(bus.s_axi_rvalid),  128'(0));
    chk("rst rdata",   128'(bus.s_axi_rdata),   128'(0));
    chk("rst reg_out", reg_out, 128'(0));

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, ok);
        chk($sformatf("v%0d wr done", i), 128'(ok), 128'(1));
        chk($sformatf("v%0d bresp", i), 128'(resp), 128'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, rdata, resp, ok);
        chk($sformatf("v%0d rd done", i), 128'(ok), 128'(1));
        chk($sformatf("v%0d rresp", i), 128'(resp), 128'(vecs[i].exp_resp));
        chk($sformatf("v%0d rdata", i), 128'(rdata), 128'(vecs[i].exp_rdata));
      end
      if (i == 3) chk("reg_out 4 writes", reg_out, 128'h00000004_00000003_00000002_00000001);
    end
    chk("reg_out table end", reg_out, {32'h4, 32'h3, 32'h2, REG0_END});

    // W arrives three cycles before AW
    bus.s_axi_wdata = 32'h55; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    chk("A wready c0", 128'(bus.s_axi_wready), 128'(1));
    step();
    bus.s_axi_wvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("A wready c%0d", c), 128'(bus.s_axi_wready), 128'(0));
      chk($sformatf("A bvalid c%0d", c), 128'(bus.s_axi_bvalid), 128'(0));
      if (c == 3) begin bus.s_axi_awaddr = 5'h08; bus.s_axi_awvalid = 1'b1; end
      step();
    end
    bus.s_axi_awvalid = 1'b0;
    chk("A bvalid c4", 128'(bus.s_axi_bvalid), 128'(1));
    chk("A bresp c4",  128'(bus.s_axi_bresp),  128'(0));
    chk("A reg2",      128'(reg_out[95:64]),   128'(32'h55));
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("A hold bvalid %0d", k),  128'(bus.s_axi_bvalid),  128'(1));
      chk($sformatf("A hold bresp %0d", k),   128'(bus.s_axi_bresp),   128'(0));
      chk($sformatf("A hold awready %0d", k), 128'(bus.s_axi_awready), 128'(0));
      chk($sformatf("A hold wready %0d", k),  128'(bus.s_axi_wready),  128'(0));
    end
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    chk("A post bvalid",  128'(bus.s_axi_bvalid),  128'(0));
    chk("A post awready", 128'(bus.s_axi_awready), 128'(1));
    chk("A post wready",  128'(bus.s_axi_wready),  128'(1));

    // Same-edge read and write of reg1, then R held off
    bus.s_axi_araddr = 5'h04; bus.s_axi_arvalid = 1'b1;
    bus.s_axi_awaddr = 5'h04; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata = 32'h99; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_arvalid = 1'b0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("B rvalid",    128'(bus.s_axi_rvalid), 128'(1));
    chk("B rdata old", 128'(bus.s_axi_rdata),  128'(32'h2));
    chk("B reg1 new",  128'(reg_out[63:32]),   128'(32'h99));
    chk("B bvalid",    128'(bus.s_axi_bvalid), 128'(1));
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("B hold rvalid %0d", k),  128'(bus.s_axi_rvalid),  128'(1));
      chk($sformatf("B hold rdata %0d", k),   128'(bus.s_axi_rdata),   128'(32'h2));
      chk($sformatf("B hold rresp %0d", k),   128'(bus.s_axi_rresp),   128'(0));
      chk($sformatf("B hold arready %0d", k), 128'(bus.s_axi_arready), 128'(0));
    end
    bus.s_axi_rready = 1'b1; bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_rready = 1'b0; bus.s_axi_bready = 1'b0;
    chk("B post rvalid",  128'(bus.s_axi_rvalid),  128'(0));
    chk("B post arready", 128'(bus.s_axi_arready), 128'(1));
    chk("B post bvalid",  128'(bus.s_axi_bvalid),  128'(0));
    axi_read(5'h04, rdata, resp, ok);
    chk("B reread done", 128'(ok), 128'(1));
    chk("B reread",      128'(rdata), 128'(32'h99));
    chk("B reg_out",     reg_out, {32'h4, 32'h55, 32'h99, REG0_END});

    // Reset with a pending B, then with AW buffered
    bus.s_axi_awaddr = 5'h0C; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wdata = 32'h77; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("C pend bvalid", 128'(bus.s_axi_bvalid), 128'(1));
    chk("C pend reg3",   128'(reg_out[127:96]),  128'(32'h77));
    rst = 1'b1;
    step();
    chk("C in rst awready", 128'(bus.s_axi_awready), 128'(0));
    chk("C in rst wready",  128'(bus.s_axi_wready),  128'(0));
    chk("C in rst arready", 128'(bus.s_axi_arready), 128'(0));
    chk("C in rst bvalid",  128'(bus.s_axi_bvalid),  128'(0));
    chk("C in rst reg_out", reg_out, 128'(0));
    rst = 1'b0;
    step();
    chk("C after awready", 128'(bus.s_axi_awready), 128'(1));
    chk("C after wready",  128'(bus.s_axi_wready),  128'(1));
    chk("C after arready", 128'(bus.s_axi_arready), 128'(1));
    chk("C after bvalid",  128'(bus.s_axi_bvalid),  128'(0));
    chk("C after rvalid",  128'(bus.s_axi_rvalid),  128'(0));
    bus.s_axi_awaddr = 5'h04; bus.s_axi_awvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0;
    chk("C aw buffered", 128'(bus.s_axi_awready), 128'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("C aw flushed", 128'(bus.s_axi_awready), 128'(1));
    bus.s_axi_wdata = 32'h11; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("C no late B %0d", k), 128'(bus.s_axi_bvalid), 128'(0));
      chk($sformatf("C w held %0d", k),    128'(bus.s_axi_wready), 128'(0));
      step();
    end
    bus.s_axi_awaddr = 5'h08; bus.s_axi_awvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0;
    chk("C late aw bvalid", 128'(bus.s_axi_bvalid), 128'(1));
    chk("C late aw reg_out", reg_out, 128'h00000000_00000011_00000000_00000000);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    chk("C b done", 128'(bus.s_axi_bvalid), 128'(0));
    axi_write(5'h0C, 32'hCAFEF00D, 4'hF, resp, ok);
    chk("C wr done",  128'(ok),   128'(1));
    chk("C wr bresp", 128'(resp), 128'(0));
    axi_read(5'h0C, rdata, resp, ok);
    chk("C rd done",  128'(ok),    128'(1));
    chk("C rd rresp", 128'(resp),  128'(0));
    chk("C rd rdata", 128'(rdata), 128'(32'hCAFEF00D));
    chk("C final reg_out", reg_out, 128'hCAFEF00D_00000011_00000000_00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
AXI4-Lite slave register bank that sits directly downstream of the AXI VIP master in the myip_1 block design. It is the S00_AXI endpoint the master drives. It provides NUM_REGS software-visible 32-bit read/write registers with byte-strobe writes, independent AW/W acceptance and single-outstanding read/write channels. Register contents are also exported in parallel to user logic.

Parameters:
DATA_WIDTH, 32, AXI data width (only 32 supported)
ADDR_WIDTH, 4, byte address width; register index = addr[ADDR_WIDTH-1:2]
NUM_REGS, 4, number of implemented registers (<= 2**(ADDR_WIDTH-2))

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
reg_out  out  NUM_REGS*32  flattened register contents, reg i at [32i+31:32i]

Behaviour:
- Reset (ARESET high at a rising edge): all registers 0. awready, wready, arready = 0 during reset and 1 in the first cycle after it. bvalid, rvalid = 0. bresp, rresp, rdata = 0. AW/W holding buffers are emptied and any in-flight transaction is discarded with no response.
- Write path: AW and W are accepted independently, each into a one-entry holding buffer.
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - Commit happens at the edge where both address and data are available, i.e. already buffered or handshaking in that cycle. Same-cycle AW+W commits at that edge.
  - On commit: byte k of reg[idx] is updated iff wstrb[k]; buffers are cleared; bvalid=1 with bresp=OKAY (2'b00) from the next cycle.
  - bvalid and bresp are held until bready. After the B handshake, awready and wready return high the next cycle.
  - Minimum write latency: handshake at cycle N, bvalid at N+1, reg_out updated at N+1.
- Write FSM states: W_IDLE (collecting AW/W), W_RESP (bvalid high). W_IDLE->W_RESP on commit; W_RESP->W_IDLE on bready.
- Read path states: R_IDLE (arready=1), R_DATA (rvalid=1, arready=0).
  - AR handshake at N: rdata is captured from the register value before any write committing at the same edge (read-old); rvalid=1 at N+1.
  - rdata and rresp are held stable until rready. arready returns high in the cycle after the R handshake.
- Read and write channels are fully independent. A simultaneous read and write to the same register returns the old value.
- Unused high address bits beyond index: addr[1:0] is ignored.

Optional Feature:
AXIL_DECODE_ERR_EN.
- Defined: an index >= NUM_REGS returns SLVERR (2'b10). Writes leave all registers unchanged; reads return rdata=0.
- Undefined: the index is taken modulo NUM_REGS (aliasing), responses are always OKAY, and behaviour is otherwise identical.

Decomposition:
- Package axil_reg_pkg:
  - resp_t with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - wr_state_t and rd_state_t enums
  - STRB_WIDTH = DATA_WIDTH/8
  - a byte-merge function (old, new, strb)
- One sub-module, axil_reg_wr_ctrl: AW/W holding buffers, write FSM, and the commit/index/error output. The top level holds the register array and the read FSM.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (wstrb=0xF), then read back the same addresses -> rdata 0x1..0x4, every bresp/rresp=OKAY, reg_out=0x00000004_00000003_00000002_00000001.
- reg0=0x00000001; write 0xAABBCCDD with wstrb=4'b0101 -> read 0x0 returns 0x00BB00DD.
- W valid at cycle 0, AW valid at cycle 3 (addr 0x8, data 0x55) -> wready low cycles 1-3, commit at cycle 3 edge, bvalid at cycle 4, reg2=0x55.
- bready held low 5 cycles after a write -> bvalid held, bresp stable, awready/wready low throughout; rready low 5 cycles -> rdata stable, arready low.
- ADDR_WIDTH=5, access addr 0x10 -> with AXIL_DECODE_ERR_EN: bresp/rresp=SLVERR, rdata=0, regs unchanged; without it: the write lands in reg0 and responses are OKAY.
- Assert ARESET for 1 cycle with AW buffered and bvalid pending -> bvalid=0, all regs 0, no late B; a subsequent write behaves normally.
